// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Per-lane load/store handshake between SIMD LSU lanes (master) and the data
// memory responder (slave).
//   mem_read_valid / mem_write_valid : per-lane requests, held until ack
//   mem_addr / mem_write_data        : per-lane address and write data
//   mem_read_ack / mem_write_ack     : one-cycle completion pulses
//   mem_read_data                    : per-lane read result
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int DATA_WIDTH          = 64,
    parameter int DATA_REG_ADDR_WIDTH = 7,
    parameter int LANE_WIDTH          = 16
);
    logic [LANE_WIDTH-1:0]          mem_read_valid;
    logic [LANE_WIDTH-1:0]          mem_write_valid;
    logic [DATA_REG_ADDR_WIDTH-1:0] mem_addr       [LANE_WIDTH];
    logic [DATA_WIDTH-1:0]          mem_write_data [LANE_WIDTH];
    logic [LANE_WIDTH-1:0]          mem_read_ack;
    logic [LANE_WIDTH-1:0]          mem_write_ack;
    logic [DATA_WIDTH-1:0]          mem_read_data  [LANE_WIDTH];

    modport master (
        output mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
        input  mem_read_ack, mem_write_ack, mem_read_data
    );

    modport slave (
        input  mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
        output mem_read_ack, mem_write_ack, mem_read_data
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory end of the SIMD per-lane load/store handshake. Holds a
// 2^DATA_REG_ADDR_WIDTH word array, arbitrates LANE_WIDTH lanes onto
// NUM_CHANNELS access slots round-robin, and completes each granted access
// ACCESS_LATENCY cycles after its grant with a one-cycle per-lane ack.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears array too)
//   bus       : per-lane request/ack interface (slave side)
//   init_we, init_addr, init_data : backdoor preload write port
//   busy      : high while any lane is not idle
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DATA_WIDTH          = 64,
    parameter int DATA_REG_ADDR_WIDTH = 7,
    parameter int LANE_WIDTH          = 16,
    parameter int NUM_CHANNELS        = 4,
    parameter int ACCESS_LATENCY      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    data_mem_responder_if.slave            bus,
    input  logic                           init_we,
    input  logic [DATA_REG_ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0]          init_data,
    output logic                           busy
);
    localparam int DEPTH = 1 << DATA_REG_ADDR_WIDTH;
    localparam int PTR_W = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACCESS_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] LAST_LANE  = PTR_W'(LANE_WIDTH - 1);
    localparam logic [SUM_W-1:0] LANE_COUNT = SUM_W'(LANE_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PENDING      = 3'd1,
        ST_ACCESS       = 3'd2,
        ST_RESPOND      = 3'd3,
        ST_WAIT_RELEASE = 3'd4
    } lane_state_t;

    lane_state_t                    state_r      [LANE_WIDTH];
    lane_state_t                    state_next_s [LANE_WIDTH];
    logic [LANE_WIDTH-1:0]          op_write_r;
    logic [DATA_REG_ADDR_WIDTH-1:0] addr_lat_r   [LANE_WIDTH];
    logic [DATA_WIDTH-1:0]          wdata_lat_r  [LANE_WIDTH];
    logic [CNT_W-1:0]               cnt_r        [LANE_WIDTH];
    logic [DATA_WIDTH-1:0]          read_data_r  [LANE_WIDTH];
    logic [LANE_WIDTH-1:0]          read_ack_r;
    logic [LANE_WIDTH-1:0]          write_ack_r;
    logic [DATA_WIDTH-1:0]          mem_r        [DEPTH];
    logic [PTR_W-1:0]               rr_r;

    logic [PTR_W-1:0]               rr_next_s;
    logic [LANE_WIDTH-1:0]          grant_s;
    logic [LANE_WIDTH-1:0]          complete_s;
    logic [LANE_WIDTH-1:0]          lane_valid_s;
    logic [SUM_W-1:0]               lane_sum_s;
    logic [PTR_W-1:0]               scan_idx_s;
    int                             busy_slots_s;
    int                             free_slots_s;
    int                             granted_s;

    // Round-robin grant: only lanes still counting down hold a slot, so a
    // lane completing this edge frees its slot for a grant at the same edge.
    always_comb begin
        busy_slots_s = 0;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            if (state_r[i] == ST_ACCESS && cnt_r[i] != CNT_ZERO) begin
                busy_slots_s = busy_slots_s + 1;
            end else begin
                busy_slots_s = busy_slots_s;
            end
        end
        free_slots_s = NUM_CHANNELS - busy_slots_s;
        granted_s    = 0;
        grant_s      = {LANE_WIDTH{1'b0}};
        rr_next_s    = rr_r;
        lane_sum_s   = {SUM_W{1'b0}};
        scan_idx_s   = {PTR_W{1'b0}};
        for (int k = 0; k < LANE_WIDTH; k++) begin
            // Rotate from rr_r with an explicit wrap so any lane count works.
            lane_sum_s = {1'b0, rr_r} + SUM_W'(k);
            if (lane_sum_s >= LANE_COUNT) begin
                lane_sum_s = lane_sum_s - LANE_COUNT;
            end else begin
                lane_sum_s = lane_sum_s;
            end
            scan_idx_s = lane_sum_s[PTR_W-1:0];
            if (state_r[scan_idx_s] == ST_PENDING && granted_s < free_slots_s) begin
                grant_s[scan_idx_s] = 1'b1;
                granted_s           = granted_s + 1;
                rr_next_s           = (scan_idx_s == LAST_LANE) ? {PTR_W{1'b0}}
                                                                : scan_idx_s + 1'b1;
            end else begin
                granted_s = granted_s;
            end
        end
    end

    // Per-lane next-state logic, completion detect and busy flag.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            lane_valid_s[i] = bus.mem_read_valid[i] | bus.mem_write_valid[i];
            complete_s[i]   = (state_r[i] == ST_ACCESS) && (cnt_r[i] == CNT_ZERO);
            state_next_s[i] = state_r[i];
            if (state_r[i] != ST_IDLE) begin
                busy = 1'b1;
            end else begin
                busy = busy;
            end
            case (state_r[i])
                ST_IDLE: begin
                    if (lane_valid_s[i]) state_next_s[i] = ST_PENDING;
                    else                 state_next_s[i] = ST_IDLE;
                end
                ST_PENDING: begin
                    if (grant_s[i]) state_next_s[i] = ST_ACCESS;
                    else            state_next_s[i] = ST_PENDING;
                end
                ST_ACCESS: begin
                    if (complete_s[i]) state_next_s[i] = ST_RESPOND;
                    else               state_next_s[i] = ST_ACCESS;
                end
                ST_RESPOND: begin
                    // A still-held valid parks the lane so it is not re-served.
                    if (lane_valid_s[i]) state_next_s[i] = ST_WAIT_RELEASE;
                    else                 state_next_s[i] = ST_IDLE;
                end
                ST_WAIT_RELEASE: begin
                    if (lane_valid_s[i]) state_next_s[i] = ST_WAIT_RELEASE;
                    else                 state_next_s[i] = ST_IDLE;
                end
                default: state_next_s[i] = ST_IDLE;
            endcase
        end
    end

    // Lane state, latched requests, acks, read data and the word array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r        <= {PTR_W{1'b0}};
            op_write_r  <= {LANE_WIDTH{1'b0}};
            read_ack_r  <= {LANE_WIDTH{1'b0}};
            write_ack_r <= {LANE_WIDTH{1'b0}};
            for (int i = 0; i < LANE_WIDTH; i++) begin
                state_r[i]     <= ST_IDLE;
                addr_lat_r[i]  <= {DATA_REG_ADDR_WIDTH{1'b0}};
                wdata_lat_r[i] <= {DATA_WIDTH{1'b0}};
                cnt_r[i]       <= CNT_ZERO;
                read_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_r[j] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            rr_r <= rr_next_s;
            for (int i = 0; i < LANE_WIDTH; i++) begin
                state_r[i] <= state_next_s[i];
                if (grant_s[i]) begin
                    // Write takes precedence when both valids are high.
                    op_write_r[i]  <= bus.mem_write_valid[i];
                    addr_lat_r[i]  <= bus.mem_addr[i];
                    wdata_lat_r[i] <= bus.mem_write_data[i];
                    cnt_r[i]       <= CNT_LOAD;
                end else if (state_r[i] == ST_ACCESS && cnt_r[i] != CNT_ZERO) begin
                    cnt_r[i] <= cnt_r[i] - 1'b1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
                read_ack_r[i]  <= complete_s[i] & ~op_write_r[i];
                write_ack_r[i] <= complete_s[i] &  op_write_r[i];
                // Array reads here see the pre-edge value, so a read completing
                // alongside a write to the same word returns the old data.
                if (complete_s[i] && !op_write_r[i]) begin
                    read_data_r[i] <= mem_r[addr_lat_r[i]];
                end else begin
                    read_data_r[i] <= read_data_r[i];
                end
            end
            if (init_we) begin
                mem_r[init_addr] <= init_data;
            end
            // Later assignments win: lane writes override the preload port and
            // the highest completing lane wins a same-address collision.
            for (int i = 0; i < LANE_WIDTH; i++) begin
                if (complete_s[i] && op_write_r[i]) begin
                    mem_r[addr_lat_r[i]] <= wdata_lat_r[i];
                end
            end
        end
    end

    assign bus.mem_read_ack  = read_ack_r;
    assign bus.mem_write_ack = write_ack_r;

    for (genvar g = 0; g < LANE_WIDTH; g++) begin : g_rdata
        assign bus.mem_read_data[g] = read_data_r[g];
    end
endmodule
